// File: rtl/picomips_pkg.sv
// Shared picoMIPS opcode map and sequencer state encoding.
// With a 3-bit opcode there is no HALT code: the assembler emits a BEQ-to-self with Z forced. OP_HALT (8) is reachable only when Osize is 4.
package picomips_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_MULI = 4'd4;
    localparam logic [3:0] OP_BEQ  = 4'd5;
    localparam logic [3:0] OP_BNE  = 4'd6;
    localparam logic [3:0] OP_WAIT = 4'd7;
    localparam logic [3:0] OP_HALT = 4'd8;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t S_RUN   = 3'd0;
    localparam seq_state_t S_MUL   = 3'd1;
    localparam seq_state_t S_WAITP = 3'd2;
    localparam seq_state_t S_WAITR = 3'd3;
    localparam seq_state_t S_HALT  = 3'd4;

endpackage

// File: rtl/pc_sequencer_mul_stall_counter.sv
// Multiply stall counter: load, decrement, and report when zero.
// Latency: a load or decrement is visible on the next cycle. Backpressure: none; it only stalls the sequencer.
// A load takes priority over a decrement. The counter never decrements below zero.
module mul_stall_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pc_sequencer.sv
// picoMIPS PC and write-enable sequencer: it stalls for multiplies and input handshakes, and freezes on HALT.
// Outputs are combinational in the current cycle. The PC is held (no PCincr or PCrelbranch) during a stall.
// The macro PCSEQ_BRCOUNT_EN builds the taken-branch counter br_count.
module pc_sequencer
    import picomips_pkg::*;
#(
    parameter int Osize      = 3,
    parameter int MUL_CYCLES = 3,
    parameter int CNTsize    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [Osize-1:0]   opcode,
    input  logic               Z,
    input  logic               in_valid,
    output logic               PCincr,
    output logic               PCrelbranch,
    output logic               RegWE,
    output logic               in_sel,
    output logic               halted,
    output logic [CNTsize-1:0] br_count
);

    localparam bit         MUL_SINGLE = (MUL_CYCLES == 1);
    localparam logic [3:0] MUL_LOAD   = (MUL_CYCLES >= 2) ? 4'(MUL_CYCLES - 2) : 4'd0;

    seq_state_t state_q;
    seq_state_t state_d;
    logic [3:0] op4;
    logic       mul_load;
    logic       mul_dec;
    logic       mul_zero;
    logic       pc_incr_raw;
    logic       pc_br_raw;
    logic       reg_we_raw;
    logic       in_sel_raw;

    assign op4 = 4'(opcode);

    always_comb begin
        state_d     = state_q;
        pc_incr_raw = 1'b0;
        pc_br_raw   = 1'b0;
        reg_we_raw  = 1'b0;
        in_sel_raw  = 1'b0;
        mul_load    = 1'b0;
        mul_dec     = 1'b0;
        case (state_q)
            S_RUN: begin
                case (op4)
                    OP_ADD, OP_ADDI, OP_SUB: begin
                        pc_incr_raw = 1'b1;
                        reg_we_raw  = 1'b1;
                    end
                    OP_BEQ: begin
                        pc_br_raw   = Z;
                        pc_incr_raw = ~Z;
                    end
                    OP_BNE: begin
                        pc_br_raw   = ~Z;
                        pc_incr_raw = Z;
                    end
                    OP_MUL, OP_MULI: begin
                        if (MUL_SINGLE) begin
                            pc_incr_raw = 1'b1;
                            reg_we_raw  = 1'b1;
                        end else begin
                            mul_load = 1'b1;
                            state_d  = S_MUL;
                        end
                    end
                    OP_WAIT: state_d = S_WAITP;
                    OP_HALT: state_d = S_HALT;
                    default: pc_incr_raw = 1'b1;
                endcase
            end
            S_MUL: begin
                if (mul_zero) begin
                    pc_incr_raw = 1'b1;
                    reg_we_raw  = 1'b1;
                    state_d     = S_RUN;
                end else begin
                    mul_dec = 1'b1;
                end
            end
            S_WAITP: begin
                if (in_valid) begin
                    reg_we_raw = 1'b1;
                    in_sel_raw = 1'b1;
                    state_d    = S_WAITR;
                end
            end
            S_WAITR: begin
                if (!in_valid) begin
                    pc_incr_raw = 1'b1;
                    state_d     = S_RUN;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RUN;
        endcase
    end

    // Reset masks the pulses so that an aborted multiply or capture never writes the register file.
    assign PCincr      = pc_incr_raw & ~reset;
    assign PCrelbranch = pc_br_raw   & ~reset;
    assign RegWE       = reg_we_raw  & ~reset;
    assign in_sel      = in_sel_raw  & ~reset;
    assign halted      = (state_q == S_HALT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    mul_stall_counter #(.W(4)) u_mul_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (mul_load),
        .load_val_i (MUL_LOAD),
        .dec_i      (mul_dec),
        .zero_o     (mul_zero)
    );

`ifdef PCSEQ_BRCOUNT_EN
    logic [CNTsize-1:0] br_q;
    logic [CNTsize-1:0] br_d;

    assign br_d = PCrelbranch ? br_q + 1'b1 : br_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            br_q <= '0;
        end else begin
            br_q <= br_d;
        end
    end

    assign br_count = br_q;
`else
    assign br_count = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer. It uses three instances (MUL_CYCLES 3, 1 and 5) and per-cycle expectations checked through a scoreboard.
module tb_pc_sequencer;
    import picomips_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] opcode;
    logic       Z;
    logic       in_valid;

    logic pci_a, pcb_a, we_a, sel_a, hlt_a;
    logic pci_b, pcb_b, we_b, sel_b, hlt_b;
    logic pci_c, pcb_c, we_c, sel_c, hlt_c;
    logic [15:0] br_a, br_b, br_c;

    pc_sequencer #(.Osize(4), .MUL_CYCLES(3), .CNTsize(16)) dut_a (
        .clk(clk), .reset(reset), .opcode(opcode), .Z(Z), .in_valid(in_valid),
        .PCincr(pci_a), .PCrelbranch(pcb_a), .RegWE(we_a), .in_sel(sel_a),
        .halted(hlt_a), .br_count(br_a));

    pc_sequencer #(.Osize(4), .MUL_CYCLES(1), .CNTsize(16)) dut_b (
        .clk(clk), .reset(reset), .opcode(opcode), .Z(Z), .in_valid(in_valid),
        .PCincr(pci_b), .PCrelbranch(pcb_b), .RegWE(we_b), .in_sel(sel_b),
        .halted(hlt_b), .br_count(br_b));

    pc_sequencer #(.Osize(4), .MUL_CYCLES(5), .CNTsize(16)) dut_c (
        .clk(clk), .reset(reset), .opcode(opcode), .Z(Z), .in_valid(in_valid),
        .PCincr(pci_c), .PCrelbranch(pcb_c), .RegWE(we_c), .in_sel(sel_c),
        .halted(hlt_c), .br_count(br_c));

    // The vector layout is {halted, in_sel, RegWE, PCrelbranch, PCincr}.
    localparam logic [4:0] V_IDLE = 5'b00000;
    localparam logic [4:0] V_EXEC = 5'b00101;
    localparam logic [4:0] V_INC  = 5'b00001;
    localparam logic [4:0] V_BR   = 5'b00010;
    localparam logic [4:0] V_CAP  = 5'b01100;
    localparam logic [4:0] V_HALT = 5'b10000;

    typedef struct {
        int         inst;
        logic       rst;
        logic [4:0] vec;
        string      tag;
    } exp_t;

    exp_t sbq[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   br_model  = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] outs(input int inst);
        case (inst)
            0:       return {hlt_a, sel_a, we_a, pcb_a, pci_a};
            1:       return {hlt_b, sel_b, we_b, pcb_b, pci_b};
            default: return {hlt_c, sel_c, we_c, pcb_c, pci_c};
        endcase
    endfunction

    // This task drives one cycle of inputs and records the expectation. It then checks at the negedge and advances to the next posedge.
    task automatic cyc(input string tag, input int inst, input logic rst, input logic [3:0] op,
                       input logic z, input logic iv, input logic [4:0] exp);
        exp_t       e;
        logic [15:0] br_exp;
        reset    = rst;
        opcode   = op;
        Z        = z;
        in_valid = iv;
        e.inst = inst;
        e.rst  = rst;
        e.vec  = exp;
        e.tag  = tag;
        sbq.push_back(e);
        @(negedge clk);
        e = sbq.pop_front();
        check_eq(e.tag, {11'd0, outs(e.inst)}, {11'd0, e.vec});
        if (e.inst == 0) begin
`ifdef PCSEQ_BRCOUNT_EN
            br_exp = 16'(br_model);
`else
            br_exp = 16'd0;
`endif
            check_eq({e.tag, "/br"}, br_a, br_exp);
        end
        if (e.rst) br_model = 0;
        else if (e.vec[1]) br_model++;
        @(posedge clk);
        #1;
    endtask

    task automatic clean_reset();
        reset    = 1'b1;
        opcode   = OP_ADD;
        Z        = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        br_model = 0;
    endtask

    initial begin
        clean_reset();
        cyc("rst_a", 0, 1'b1, OP_ADD, 1'b0, 1'b0, V_IDLE);

        for (int i = 0; i < 3; i++) cyc("add", 0, 1'b0, OP_ADD, 1'b0, 1'b0, V_EXEC);
        cyc("addi", 0, 1'b0, OP_ADDI, 1'b0, 1'b0, V_EXEC);
        cyc("sub",  0, 1'b0, OP_SUB,  1'b1, 1'b0, V_EXEC);

        cyc("beq_z1", 0, 1'b0, OP_BEQ, 1'b1, 1'b0, V_BR);
        cyc("beq_z0", 0, 1'b0, OP_BEQ, 1'b0, 1'b0, V_INC);
        cyc("bne_z0", 0, 1'b0, OP_BNE, 1'b0, 1'b0, V_BR);
        cyc("bne_z1", 0, 1'b0, OP_BNE, 1'b1, 1'b0, V_INC);
        cyc("undef",  0, 1'b0, 4'd12,  1'b0, 1'b0, V_INC);

        cyc("mul3_c1", 0, 1'b0, OP_MUL, 1'b0, 1'b0, V_IDLE);
        cyc("mul3_c2", 0, 1'b0, OP_MUL, 1'b0, 1'b0, V_IDLE);
        cyc("mul3_c3", 0, 1'b0, OP_MUL, 1'b0, 1'b0, V_EXEC);
        cyc("muli3_c1", 0, 1'b0, OP_MULI, 1'b0, 1'b0, V_IDLE);
        cyc("muli3_c2", 0, 1'b0, OP_ADD,  1'b0, 1'b0, V_IDLE);
        cyc("muli3_c3", 0, 1'b0, OP_ADD,  1'b0, 1'b0, V_EXEC);
        cyc("post_mul", 0, 1'b0, OP_ADD,  1'b0, 1'b0, V_EXEC);

        cyc("wait_dec", 0, 1'b0, OP_WAIT, 1'b0, 1'b0, V_IDLE);
        for (int i = 0; i < 4; i++) cyc("waitp_lo", 0, 1'b0, OP_WAIT, 1'b0, 1'b0, V_IDLE);
        cyc("press", 0, 1'b0, OP_WAIT, 1'b0, 1'b1, V_CAP);
        for (int i = 0; i < 4; i++) cyc("waitr_hi", 0, 1'b0, OP_ADD, 1'b0, 1'b1, V_IDLE);
        cyc("release", 0, 1'b0, OP_ADD, 1'b0, 1'b0, V_INC);
        cyc("post_wait", 0, 1'b0, OP_ADD, 1'b0, 1'b0, V_EXEC);

        cyc("wait_pre_hi", 0, 1'b0, OP_WAIT, 1'b0, 1'b1, V_IDLE);
        cyc("press_pre",   0, 1'b0, OP_WAIT, 1'b0, 1'b1, V_CAP);
        cyc("release_pre", 0, 1'b0, OP_ADD,  1'b0, 1'b0, V_INC);

        cyc("halt_dec", 0, 1'b0, OP_HALT, 1'b0, 1'b0, V_IDLE);
        for (int i = 0; i < 10; i++) begin
            logic [3:0] rop;
            rop = 4'($urandom_range(0, 15));
            cyc("halted", 0, 1'b0, rop, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), V_HALT);
        end
        cyc("halt_rst", 0, 1'b1, OP_ADD, 1'b1, 1'b1, V_HALT);
        cyc("after_halt", 0, 1'b0, OP_ADD, 1'b0, 1'b0, V_EXEC);
        cyc("after_halt_br", 0, 1'b0, OP_BEQ, 1'b1, 1'b0, V_BR);

        clean_reset();
        cyc("mul1_a", 1, 1'b0, OP_MUL,  1'b0, 1'b0, V_EXEC);
        cyc("mul1_b", 1, 1'b0, OP_MULI, 1'b0, 1'b0, V_EXEC);
        cyc("mul1_add", 1, 1'b0, OP_ADD, 1'b0, 1'b0, V_EXEC);

        clean_reset();
        cyc("mul5_c1", 2, 1'b0, OP_MUL, 1'b0, 1'b0, V_IDLE);
        for (int i = 0; i < 3; i++) cyc("mul5_stall", 2, 1'b0, OP_ADD, 1'b0, 1'b0, V_IDLE);
        cyc("mul5_c5", 2, 1'b0, OP_ADD, 1'b0, 1'b0, V_EXEC);

        cyc("mul5r_c1", 2, 1'b0, OP_MUL, 1'b0, 1'b0, V_IDLE);
        cyc("mul5r_c2", 2, 1'b0, OP_ADD, 1'b0, 1'b0, V_IDLE);
        cyc("mul5r_rst", 2, 1'b1, OP_ADD, 1'b0, 1'b0, V_IDLE);
        cyc("mul5r_add1", 2, 1'b0, OP_ADD, 1'b0, 1'b0, V_EXEC);
        cyc("mul5r_add2", 2, 1'b0, OP_ADD, 1'b0, 1'b0, V_EXEC);

        if (sbq.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: %0d entries left, required 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
